// File: rtl/reaction_timer_core.sv
// Reaction-timer trial sequencer: start press, pseudo-random pre-light delay,
// then millisecond measurement until stop press, with early-press and timeout faults.
module reaction_timer_core #(
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned MAX_MS       = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1khz,
  input  logic        start,
  input  logic        stop,
  output logic        led,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic        too_soon,
  output logic        timeout,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_EARLY = 3'd4;
  localparam logic [2:0] S_TOUT  = 3'd5;

  localparam logic [10:0] MIN_D   = 11'(MIN_DELAY_MS);
  localparam logic [13:0] MAX_C   = 14'(MAX_MS);
  localparam logic [13:0] MAX_M1  = 14'(MAX_MS - 1);

  logic [2:0]  state_q, state_d;
  logic        start_q, stop_q;
  logic [15:0] lfsr_q;
  logic [10:0] delay_q, delay_d;
  logic [13:0] ms_q, ms_d;
  logic [13:0] result_q, result_d;
  logic        led_q, led_d;
  logic        valid_q, valid_d;
  logic        soon_q, soon_d;
  logic        tout_q, tout_d;
  logic        busy_q, busy_d;
  logic        start_ev_s, stop_ev_s;

  // Fibonacci LFSR, taps 16,14,13,11, shifted left with feedback into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign start_ev_s = start & ~start_q;
  assign stop_ev_s  = stop & ~stop_q;

  // Next-state and next-output logic; all outputs are registered copies of these.
  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    ms_d     = ms_q;
    result_d = result_q;
    led_d    = led_q;
    valid_d  = valid_q;
    soon_d   = soon_q;
    tout_d   = tout_q;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE, S_DONE, S_EARLY, S_TOUT: begin
        if (start_ev_s) begin
          state_d  = S_WAIT;
          delay_d  = MIN_D + {1'b0, lfsr_q[9:0]};
          result_d = 14'd0;
          valid_d  = 1'b0;
          soon_d   = 1'b0;
          tout_d   = 1'b0;
          busy_d   = 1'b1;
          led_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_WAIT: begin
        // A stop press beats a coincident final tick.
        if (stop_ev_s) begin
          state_d = S_EARLY;
          soon_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (tick_1khz) begin
          delay_d = delay_q - 11'd1;
          if (delay_q == 11'd1) begin
            state_d = S_ARMED;
            led_d   = 1'b1;
            ms_d    = 14'd0;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_ARMED: begin
        if (stop_ev_s) begin
          state_d  = S_DONE;
          result_d = ms_q;
          valid_d  = 1'b1;
          led_d    = 1'b0;
          busy_d   = 1'b0;
        end else if (tick_1khz) begin
          ms_d = ms_q + 14'd1;
          if (ms_q == MAX_M1) begin
            state_d  = S_TOUT;
            result_d = MAX_C;
            tout_d   = 1'b1;
            led_d    = 1'b0;
            busy_d   = 1'b0;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = S_IDLE;
        delay_d  = 11'd0;
        ms_d     = 14'd0;
        result_d = 14'd0;
        led_d    = 1'b0;
        valid_d  = 1'b0;
        soon_d   = 1'b0;
        tout_d   = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State, counters, edge detectors, LFSR and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      delay_q  <= 11'd0;
      ms_q     <= 14'd0;
      result_q <= 14'd0;
      led_q    <= 1'b0;
      valid_q  <= 1'b0;
      soon_q   <= 1'b0;
      tout_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      stop_q   <= stop;
      lfsr_q   <= lfsr_next(lfsr_q);
      delay_q  <= delay_d;
      ms_q     <= ms_d;
      result_q <= result_d;
      led_q    <= led_d;
      valid_q  <= valid_d;
      soon_q   <= soon_d;
      tout_q   <= tout_d;
      busy_q   <= busy_d;
    end
  end

  assign led          = led_q;
  assign result_ms    = result_q;
  assign result_valid = valid_q;
  assign too_soon     = soon_q;
  assign timeout      = tout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench for reaction_timer_core: scenario table, async-reset
// sequence and randomized presses, all checked against a trial-level model.
module tb_reaction_timer_core;

  localparam int          MIN_D = 40;
  localparam int          MAX_C = 300;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          LIM   = 30000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick_1khz, start, stop;
  logic        led, result_valid, too_soon, timeout, busy;
  logic [13:0] result_ms;

  always #5 clk = ~clk;

  reaction_timer_core #(.MIN_DELAY_MS(MIN_D), .MAX_MS(MAX_C), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .tick_1khz(tick_1khz), .start(start), .stop(stop),
    .led(led), .result_ms(result_ms), .result_valid(result_valid),
    .too_soon(too_soon), .timeout(timeout), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  typedef enum int {M_IDLE, M_WAIT, M_ARMED, M_HOLD} mmode_t;
  mmode_t      m_mode;
  logic [15:0] m_lfsr;
  bit          m_st_prev, m_sp_prev;
  int          m_delay, m_left, m_ms, e_res;
  bit          e_valid, e_soon, e_tout;
  int          tick_per, tick_div, edge_cnt;
  bit          led_seen;

  typedef struct {
    int per; bit early; int n; bit co;
    int exp_res; bit exp_valid; bit exp_soon; bit exp_tout;
  } vec_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    int fb;
    fb = int'(v[15]) ^ int'(v[13]) ^ int'(v[12]) ^ int'(v[10]);
    return 16'(((int'(v) * 2) + fb) % 65536);
  endfunction

  function automatic int lfsr_after(input int k);
    logic [15:0] v;
    v = SEED;
    for (int i = 0; i < k; i++) v = lfsr_step(v);
    return int'(v);
  endfunction

  function automatic int dut_vec();
    return int'({13'd0, led, busy, result_valid, too_soon, timeout, result_ms});
  endfunction

  function automatic int exp_vec();
    logic e_led, e_busy;
    e_led  = (m_mode == M_ARMED);
    e_busy = (m_mode == M_WAIT) || (m_mode == M_ARMED);
    return int'({13'd0, e_led, e_busy, e_valid, e_soon, e_tout, 14'(e_res)});
  endfunction

  function automatic bit tick_next();
    return tick_div == tick_per - 1;
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_lfsr = SEED; m_st_prev = 1'b0; m_sp_prev = 1'b0;
    m_delay = 0; m_left = 0; m_ms = 0; e_res = 0;
    e_valid = 1'b0; e_soon = 1'b0; e_tout = 1'b0; edge_cnt = 0;
  endtask

  // Trial-level behaviour: remaining ticks before the light, elapsed ms while lit.
  task automatic model_edge(input bit st, input bit sp, input bit tk);
    bit se, pe;
    se = st && !m_st_prev;
    pe = sp && !m_sp_prev;
    case (m_mode)
      M_IDLE, M_HOLD: if (se) begin
        m_mode = M_WAIT; m_delay = MIN_D + (int'(m_lfsr) % 1024); m_left = m_delay;
        e_res = 0; e_valid = 1'b0; e_soon = 1'b0; e_tout = 1'b0;
      end
      M_WAIT: if (pe) begin
        m_mode = M_HOLD; e_soon = 1'b1;
      end else if (tk) begin
        m_left--;
        if (m_left == 0) begin m_mode = M_ARMED; m_ms = 0; end
      end
      M_ARMED: if (pe) begin
        m_mode = M_HOLD; e_res = m_ms; e_valid = 1'b1;
      end else if (tk) begin
        m_ms++;
        if (m_ms == MAX_C) begin m_mode = M_HOLD; e_res = MAX_C; e_tout = 1'b1; end
      end
      default: m_mode = M_IDLE;
    endcase
    m_lfsr = lfsr_step(m_lfsr);
    m_st_prev = st; m_sp_prev = sp;
    edge_cnt++;
  endtask

  task automatic step(input bit st, input bit sp);
    bit tk;
    tk = tick_next();
    tick_div = tk ? 0 : tick_div + 1;
    start = st; stop = sp; tick_1khz = tk;
    @(posedge clk); #1;
    model_edge(st, sp, tk);
    check_int("cycle", dut_vec(), exp_vec());
    led_seen |= led;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0; tick_1khz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_int("reset_state", dut_vec(), 0);
    reset = 1'b1;
    tick_div = 0;
  endtask

  task automatic run_row(input vec_t r);
    int press_k, exp_delay, wt, guard;
    tick_per = r.per; tick_div = 0; led_seen = 1'b0;
    step(1'b0, 1'b0);
    press_k = edge_cnt;
    step(1'b1, 1'b0);
    check_int("clear_on_start", dut_vec(), 32'h0002_0000);
    exp_delay = MIN_D + (lfsr_after(press_k) % 1024);
    guard = 0;
    if (r.early) begin
      if (r.n >= 0) begin
        while (!((m_delay - m_left == r.n) && (!r.co || tick_next())) && guard < LIM) begin
          step(1'b0, 1'b0); guard++;
        end
      end else begin
        while (!(m_left == 1 && tick_next()) && guard < LIM) begin
          step(1'b0, 1'b0); guard++;
        end
      end
      step(1'b0, 1'b1);
    end else begin
      wt = 0;
      while (led !== 1'b1 && guard < LIM) begin
        if (tick_next() && busy && !led) wt++;
        step(1'b0, 1'b0); guard++;
      end
      check_int("led_rise_ticks", wt, exp_delay);
      if (r.n >= 0) begin
        while (!(m_ms == r.n && (!r.co || tick_next())) && guard < LIM) begin
          step(1'b0, 1'b0); guard++;
        end
        step(1'b0, 1'b1);
      end else begin
        while (led === 1'b1 && guard < LIM) begin
          step(1'b0, 1'b0); guard++;
        end
      end
    end
    check_int("wait_bound", int'(guard < LIM), 1);
    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_int("result_ms", int'(result_ms), r.exp_res);
    check_int("result_valid", int'(result_valid), int'(r.exp_valid));
    check_int("too_soon", int'(too_soon), int'(r.exp_soon));
    check_int("timeout", int'(timeout), int'(r.exp_tout));
    check_int("led_off", int'(led), 0);
    check_int("busy_off", int'(busy), 0);
    check_int("led_rose", int'(led_seen), r.early ? 0 : 1);
  endtask

  vec_t vecs[7];

  initial begin
    int guard;
    bit st, sp;
    start = 1'b0; stop = 1'b0; tick_1khz = 1'b0;
    tick_per = 1; tick_div = 0; led_seen = 1'b0;
    model_reset();
    #1;
    do_reset();

    vecs[0] = '{10, 1'b0, 237, 1'b0, 237, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1,  1'b1, 10,  1'b0, 0,   1'b0, 1'b1, 1'b0};
    vecs[2] = '{1,  1'b0, 5,   1'b1, 5,   1'b1, 1'b0, 1'b0};
    vecs[3] = '{2,  1'b0, -1,  1'b0, MAX_C, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1,  1'b0, MAX_C - 1, 1'b1, MAX_C - 1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1,  1'b1, -1,  1'b1, 0,   1'b0, 1'b1, 1'b0};
    vecs[6] = '{3,  1'b0, 0,   1'b0, 0,   1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) run_row(vecs[i]);

    // Asynchronous reset pulse while the light is on.
    tick_per = 1; tick_div = 0;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    guard = 0;
    while (led !== 1'b1 && guard < LIM) begin step(1'b0, 1'b0); guard++; end
    repeat (4) step(1'b0, 1'b0);
    check_int("armed_before_reset", int'(led), 1);
    reset = 1'b0;
    #0.5;
    check_int("async_reset", dut_vec(), 0);
    #0.5;
    reset = 1'b1;
    model_reset();
    tick_div = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_int("idle_after_reset", dut_vec(), 0);

    // Randomized button activity against the model.
    st = 1'b0; sp = 1'b0;
    for (int c = 0; c < 25000; c++) begin
      if (c % 5000 == 0) begin
        tick_per = int'($urandom_range(1, 3));
        tick_div = 0;
      end
      if ($urandom_range(0, 1499) == 0) st = ~st;
      if ($urandom_range(0, 599) == 0) sp = ~sp;
      step(st, sp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
